kronos_wb_lsu: RTL and testbench

KRONOS_WB_LSU -- requirements
Module: kronos_wb_lsu

---
 rtl/kronos_types.sv | 66 ++++++
 rtl/kronos_wb_lsu_if.sv | 20 ++
 rtl/kronos_lsu_align.sv | 30 +++
 rtl/kronos_wb_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_kronos_wb_lsu.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kronos_types.sv
// Shared types for the Kronos write-back / load-store stage: EX->WB payload,
// trap cause codes, LSU size encodings and small address helpers.
package kronos_types;

  typedef struct packed {
    logic [31:0] result1;
    logic [31:0] result2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic        ld;
    logic        st;
    logic [2:0]  funct3;
    logic        csr;
    logic        ecall;
    logic        ebreak;
    logic        ret;
    logic        wfi;
    logic        is_illegal;
  } pipeEXWB_t;

  localparam int TRAP_W = 4;

  // Values follow the RISC-V mcause exception codes.
  typedef enum logic [TRAP_W-1:0] {
    ILLEGAL     = 4'd2,
    EBREAK      = 4'd3,
    LD_MISALIGN = 4'd4,
    ST_MISALIGN = 4'd6,
    ECALL       = 4'd11
  } trap_cause_t;

  // Access size, taken from funct3[1:0].
  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  typedef enum logic [0:0] {
    STEER    = 1'b0,
    MEM_WAIT = 1'b1
  } lsu_state_t;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      LSU_BYTE: bad = 1'b0;
      LSU_HALF: bad = offset[0];
      default:  bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

  // Clears the low address bits that a naturally aligned access must not use.
  function automatic logic [31:0] force_align(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] aligned;
    case (size)
      LSU_BYTE: aligned = addr;
      LSU_HALF: aligned = {addr[31:1], 1'b0};
      default:  aligned = {addr[31:2], 2'b00};
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/kronos_wb_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface kronos_wb_lsu_if;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_addr;
  logic        data_wr_en;
  logic [3:0]  data_mask;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_wr_en, data_mask, data_wdata,
    input  data_ack, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_wr_en, data_mask, data_wdata,
    output data_ack, data_rdata
  );
endinterface

// File: rtl/kronos_lsu_align.sv
// Load-data formatter: picks the addressed lane out of the read word and
// sign- or zero-extends it according to funct3.
module kronos_lsu_align
  import kronos_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] shifted_s;
  logic        sign_s;

  // Shift the addressed lane down to bit 0, then extend it to 32 bits
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    sign_s    = 1'b0;
    case (funct3[1:0])
      LSU_BYTE: begin
        sign_s = shifted_s[7] & ~funct3[2];
        data   = {{24{sign_s}}, shifted_s[7:0]};
      end
      LSU_HALF: begin
        sign_s = shifted_s[15] & ~funct3[2];
        data   = {{16{sign_s}}, shifted_s[15:0]};
      end
      default: data = shifted_s;
    endcase
  end
endmodule

// File: rtl/kronos_wb_lsu.sv
// Kronos write-back stage with load/store unit. Non-memory ops retire one
// cycle after acceptance; loads/stores hold the bus until data_ack.
module kronos_wb_lsu
  import kronos_types::*;
#(
  parameter logic CATCH_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rstz,
  input  pipeEXWB_t         execute,
  input  logic              pipe_in_vld,
  output logic              pipe_in_rdy,
  output logic              regwr_en,
  output logic [4:0]        regwr_sel,
  output logic [31:0]       regwr_data,
  output logic              branch,
  output logic [31:0]       branch_target,
  kronos_wb_lsu_if.master   bus,
  output logic              trap,
  output logic [TRAP_W-1:0] trap_cause
);
  lsu_state_t        state_r, state_nx_s;
  logic              rdy_r;
  logic              regwr_en_r, regwr_en_nx_s;
  logic [4:0]        regwr_sel_r, regwr_sel_nx_s;
  logic [31:0]       regwr_data_r, regwr_data_nx_s;
  logic              branch_r, branch_nx_s;
  logic [31:0]       branch_tgt_r, branch_tgt_nx_s;
  logic              trap_r, trap_nx_s;
  logic [TRAP_W-1:0] cause_r, cause_nx_s;
  logic              req_r, req_nx_s;
  logic [31:0]       addr_r, addr_nx_s;
  logic              wr_en_r, wr_en_nx_s;
  logic [3:0]        mask_r, mask_nx_s;
  logic [31:0]       wdata_r, wdata_nx_s;
  logic [4:0]        ld_rd_r, ld_rd_nx_s;
  logic [2:0]        ld_f3_r, ld_f3_nx_s;

  logic [1:0]        size_s;
  logic              mem_op_s;
  logic              misalign_s;
  logic [31:0]       eff_addr_s;
  logic              trap_hit_s;
  trap_cause_t       cause_s;
  logic [3:0]        st_mask_s;
  logic [31:0]       st_wdata_s;
  logic [31:0]       ld_data_s;
  logic              accept_s;

  assign size_s     = execute.funct3[1:0];
  assign mem_op_s   = execute.ld | execute.st;
  assign misalign_s = is_misaligned(size_s, execute.result2[1:0]);
  assign eff_addr_s = CATCH_MISALIGNED ? execute.result2 : force_align(size_s, execute.result2);
  assign accept_s   = pipe_in_vld & rdy_r;

  // Exception decode with is_illegal > ecall > ebreak > system ops > misalignment
  always_comb begin
    trap_hit_s = 1'b1;
    cause_s    = ILLEGAL;
    if (execute.is_illegal) begin
      cause_s = ILLEGAL;
    end else if (execute.ecall) begin
      cause_s = ECALL;
    end else if (execute.ebreak) begin
      cause_s = EBREAK;
    end else if (execute.csr | execute.ret | execute.wfi) begin
      cause_s = ILLEGAL;
    end else if (mem_op_s & misalign_s & CATCH_MISALIGNED) begin
      cause_s = execute.st ? ST_MISALIGN : LD_MISALIGN;
    end else begin
      trap_hit_s = 1'b0;
    end
  end

  // Store byte-enables and lane-replicated write data
  always_comb begin
    case (size_s)
      LSU_BYTE: begin
        st_mask_s  = 4'b0001 << eff_addr_s[1:0];
        st_wdata_s = {4{execute.result1[7:0]}};
      end
      LSU_HALF: begin
        st_mask_s  = 4'b0011 << eff_addr_s[1:0];
        st_wdata_s = {2{execute.result1[15:0]}};
      end
      default: begin
        st_mask_s  = 4'b1111;
        st_wdata_s = execute.result1;
      end
    endcase
  end

  kronos_lsu_align u_align (
    .rdata  (bus.data_rdata),
    .offset (addr_r[1:0]),
    .funct3 (ld_f3_r),
    .data   (ld_data_s)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_nx_s      = state_r;
    regwr_en_nx_s   = 1'b0;
    regwr_sel_nx_s  = regwr_sel_r;
    regwr_data_nx_s = regwr_data_r;
    branch_nx_s     = 1'b0;
    branch_tgt_nx_s = branch_tgt_r;
    trap_nx_s       = 1'b0;
    cause_nx_s      = cause_r;
    req_nx_s        = req_r;
    addr_nx_s       = addr_r;
    wr_en_nx_s      = wr_en_r;
    mask_nx_s       = mask_r;
    wdata_nx_s      = wdata_r;
    ld_rd_nx_s      = ld_rd_r;
    ld_f3_nx_s      = ld_f3_r;
    case (state_r)
      STEER: begin
        if (accept_s) begin
          if (trap_hit_s) begin
            trap_nx_s  = 1'b1;
            cause_nx_s = cause_s;
          end else if (mem_op_s) begin
            state_nx_s = MEM_WAIT;
            req_nx_s   = 1'b1;
            addr_nx_s  = eff_addr_s;
            wr_en_nx_s = execute.st;
            ld_rd_nx_s = execute.rd;
            ld_f3_nx_s = execute.funct3;
            wdata_nx_s = st_wdata_s;
            if (execute.st) begin
              mask_nx_s = st_mask_s;
            end else begin
              mask_nx_s = 4'b1111;
            end
          end else begin
            regwr_en_nx_s   = execute.rd_write & (execute.rd != 5'd0);
            regwr_sel_nx_s  = execute.rd;
            regwr_data_nx_s = execute.result1;
            branch_nx_s     = execute.branch | (execute.branch_cond & execute.result1[0]);
            branch_tgt_nx_s = execute.result2;
          end
        end else begin
          state_nx_s = STEER;
        end
      end
      MEM_WAIT: begin
        if (bus.data_ack) begin
          state_nx_s = STEER;
          req_nx_s   = 1'b0;
          if (!wr_en_r) begin
            regwr_en_nx_s   = (ld_rd_r != 5'd0);
            regwr_sel_nx_s  = ld_rd_r;
            regwr_data_nx_s = ld_data_s;
          end else begin
            regwr_en_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = MEM_WAIT;
        end
      end
      default: state_nx_s = STEER;
    endcase
  end

  // FSM state register; reset returns to STEER and abandons any access
  always_ff @(posedge clk) begin
    if (!rstz) begin
      state_r <= STEER;
      rdy_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      rdy_r   <= (state_nx_s == STEER);
    end
  end

  // Output and access-context registers
  always_ff @(posedge clk) begin
    if (!rstz) begin
      regwr_en_r   <= 1'b0;
      regwr_sel_r  <= 5'd0;
      regwr_data_r <= 32'd0;
      branch_r     <= 1'b0;
      branch_tgt_r <= 32'd0;
      trap_r       <= 1'b0;
      cause_r      <= {TRAP_W{1'b0}};
      req_r        <= 1'b0;
      addr_r       <= 32'd0;
      wr_en_r      <= 1'b0;
      mask_r       <= 4'd0;
      wdata_r      <= 32'd0;
      ld_rd_r      <= 5'd0;
      ld_f3_r      <= 3'd0;
    end else begin
      regwr_en_r   <= regwr_en_nx_s;
      regwr_sel_r  <= regwr_sel_nx_s;
      regwr_data_r <= regwr_data_nx_s;
      branch_r     <= branch_nx_s;
      branch_tgt_r <= branch_tgt_nx_s;
      trap_r       <= trap_nx_s;
      cause_r      <= cause_nx_s;
      req_r        <= req_nx_s;
      addr_r       <= addr_nx_s;
      wr_en_r      <= wr_en_nx_s;
      mask_r       <= mask_nx_s;
      wdata_r      <= wdata_nx_s;
      ld_rd_r      <= ld_rd_nx_s;
      ld_f3_r      <= ld_f3_nx_s;
    end
  end

  assign pipe_in_rdy    = rdy_r;
  assign regwr_en       = regwr_en_r;
  assign regwr_sel      = regwr_sel_r;
  assign regwr_data     = regwr_data_r;
  assign branch         = branch_r;
  assign branch_target  = branch_tgt_r;
  assign trap           = trap_r;
  assign trap_cause     = cause_r;
  assign bus.data_req   = req_r;
  assign bus.data_addr  = addr_r;
  assign bus.data_wr_en = wr_en_r;
  assign bus.data_mask  = mask_r;
  assign bus.data_wdata = wdata_r;
endmodule

// File: tb/tb_kronos_wb_lsu.sv
// Self-checking bench for kronos_wb_lsu: directed scenarios plus randomized
// ops checked against a behavioural model of the write-back/LSU rules.
module tb_kronos_wb_lsu;
  import kronos_types::*;

  logic              clk = 1'b0;
  logic              rstz = 1'b0;
  pipeEXWB_t         execute;
  logic              pipe_in_vld;
  logic              pipe_in_rdy;
  logic              regwr_en;
  logic [4:0]        regwr_sel;
  logic [31:0]       regwr_data;
  logic              branch;
  logic [31:0]       branch_target;
  logic              trap;
  logic [TRAP_W-1:0] trap_cause;

  int n_cmp  = 0;
  int n_fail = 0;

  kronos_wb_lsu_if bus_if();

  kronos_wb_lsu #(.CATCH_MISALIGNED(1'b1)) dut (
    .clk           (clk),
    .rstz          (rstz),
    .execute       (execute),
    .pipe_in_vld   (pipe_in_vld),
    .pipe_in_rdy   (pipe_in_rdy),
    .regwr_en      (regwr_en),
    .regwr_sel     (regwr_sel),
    .regwr_data    (regwr_data),
    .branch        (branch),
    .branch_target (branch_target),
    .bus           (bus_if),
    .trap          (trap),
    .trap_cause    (trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              trap;
    logic [TRAP_W-1:0] cause;
    logic              mem;
    logic              wr;
    logic [31:0]       addr;
    logic [3:0]        mask;
    logic [31:0]       wdata;
    logic              wb_now;
    logic              wb_late;
    logic [4:0]        sel;
    logic [31:0]       wbdata;
    logic              br;
    logic [31:0]       tgt;
  } exp_t;

  // Behavioural reference: what one accepted op must produce.
  function automatic exp_t model(input pipeEXWB_t op, input logic [31:0] rdata);
    exp_t        e;
    int unsigned nbytes;
    int unsigned off;
    int unsigned a;
    logic [63:0] v;
    e      = '0;
    a      = op.result2;
    nbytes = (op.funct3[1:0] == 2'd0) ? 1 : (op.funct3[1:0] == 2'd1) ? 2 : 4;
    off    = a % 4;
    if (op.is_illegal) begin e.trap = 1'b1; e.cause = ILLEGAL; end
    else if (op.ecall) begin e.trap = 1'b1; e.cause = ECALL; end
    else if (op.ebreak) begin e.trap = 1'b1; e.cause = EBREAK; end
    else if (op.csr || op.ret || op.wfi) begin e.trap = 1'b1; e.cause = ILLEGAL; end
    else if ((op.ld || op.st) && (a % nbytes) != 0) begin
      e.trap  = 1'b1;
      e.cause = op.st ? ST_MISALIGN : LD_MISALIGN;
    end else if (op.ld || op.st) begin
      e.mem  = 1'b1;
      e.wr   = op.st;
      e.addr = op.result2;
      if (op.st) begin
        e.mask = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1)      e.wdata = 32'(op.result1[7:0]) * 32'h01010101;
        else if (nbytes == 2) e.wdata = 32'(op.result1[15:0]) * 32'h00010001;
        else                  e.wdata = op.result1;
      end else begin
        e.mask = 4'hF;
        v = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 64'd1);
        if (!op.funct3[2] && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1)))
          v = v - (64'd1 << (8 * nbytes));
        e.wbdata  = v[31:0];
        e.wb_late = (op.rd != 5'd0);
        e.sel     = op.rd;
      end
    end else begin
      e.wb_now = op.rd_write && (op.rd != 5'd0);
      e.sel    = op.rd;
      e.wbdata = op.result1;
      e.br     = op.branch || (op.branch_cond && op.result1[0]);
      e.tgt    = op.result2;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op and wait (bounded) until it is accepted; outputs of the
  // op are visible when this returns.
  task automatic send_op(input pipeEXWB_t op);
    int waited;
    waited      = 0;
    execute     = op;
    pipe_in_vld = 1'b1;
    while (pipe_in_rdy !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (pipe_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout rdy=%b required 1", pipe_in_rdy);
    end
    tick();
    pipe_in_vld = 1'b0;
  endtask

  task automatic test_reset();
    rstz = 1'b0; pipe_in_vld = 1'b0; execute = '0;
    bus_if.data_ack = 1'b0; bus_if.data_rdata = 32'd0;
    tick(); tick();
    n_cmp++;
    if ({pipe_in_rdy, regwr_en, branch, trap, bus_if.data_req, bus_if.data_wr_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 000000",
               {pipe_in_rdy, regwr_en, branch, trap, bus_if.data_req, bus_if.data_wr_en});
    end
    n_cmp++;
    if ({regwr_sel, regwr_data, branch_target, trap_cause, bus_if.data_addr,
         bus_if.data_mask, bus_if.data_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got sel=%h wd=%h tgt=%h cause=%h addr=%h mask=%h wdata=%h want all 0",
               regwr_sel, regwr_data, branch_target, trap_cause, bus_if.data_addr,
               bus_if.data_mask, bus_if.data_wdata);
    end
    rstz = 1'b1;
    tick();
    n_cmp++;
    if (pipe_in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_rdy got %b want 1", pipe_in_rdy);
    end
  endtask

  task automatic test_alu();
    pipeEXWB_t op;
    op = '0; op.rd = 5'd5; op.rd_write = 1'b1; op.result1 = 32'hDEADBEEF;
    send_op(op);
    n_cmp++;
    if ({regwr_en, regwr_sel, regwr_data, branch, trap, bus_if.data_req} !==
        {1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_wb got en=%b sel=%0d data=%h br=%b trap=%b req=%b want 1/5/deadbeef/0/0/0",
               regwr_en, regwr_sel, regwr_data, branch, trap, bus_if.data_req);
    end
    tick();
    n_cmp++;
    if (regwr_en !== 1'b0) begin n_fail++; $display("FAIL alu_pulse regwr_en=%b want 0", regwr_en); end
    op = '0; op.rd = 5'd0; op.rd_write = 1'b1; op.branch_cond = 1'b1;
    op.result1 = 32'd1; op.result2 = 32'h100;
    send_op(op);
    n_cmp++;
    if ({regwr_en, branch, branch_target} !== {1'b0, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL branch_taken got en=%b br=%b tgt=%h want 0/1/00000100", regwr_en, branch, branch_target);
    end
    tick();
    n_cmp++;
    if (branch !== 1'b0) begin n_fail++; $display("FAIL branch_pulse branch=%b want 0", branch); end
    op.result1 = 32'd2;
    send_op(op);
    n_cmp++;
    if (branch !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken branch=%b want 0", branch); end
  endtask

  task automatic test_load();
    pipeEXWB_t   op;
    logic [31:0] want [2];
    int          req_cycles;
    want[0] = 32'hFFFFFF80;
    want[1] = 32'h00000080;
    for (int k = 0; k < 2; k++) begin
      op = '0; op.ld = 1'b1; op.funct3 = (k == 0) ? 3'b000 : 3'b100;
      op.rd = 5'd7; op.rd_write = 1'b1; op.result2 = 32'h1003;
      send_op(op);
      n_cmp++;
      if ({bus_if.data_req, bus_if.data_addr, bus_if.data_wr_en, bus_if.data_mask, regwr_en} !==
          {1'b1, 32'h1003, 1'b0, 4'b1111, 1'b0}) begin
        n_fail++;
        $display("FAIL load_issue got req=%b addr=%h we=%b mask=%b en=%b want 1/00001003/0/1111/0",
                 bus_if.data_req, bus_if.data_addr, bus_if.data_wr_en, bus_if.data_mask, regwr_en);
      end
      req_cycles = (bus_if.data_req === 1'b1) ? 1 : 0;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (bus_if.data_req === 1'b1 && bus_if.data_addr === 32'h1003) req_cycles++;
      end
      bus_if.data_rdata = 32'h80FFFFFF; bus_if.data_ack = 1'b1;
      tick();
      bus_if.data_ack = 1'b0;
      n_cmp++;
      if (req_cycles !== 3) begin n_fail++; $display("FAIL load_req_hold got %0d want 3", req_cycles); end
      n_cmp++;
      if ({bus_if.data_req, regwr_en, regwr_sel, regwr_data} !== {1'b0, 1'b1, 5'd7, want[k]}) begin
        n_fail++;
        $display("FAIL load_wb k=%0d got req=%b en=%b sel=%0d data=%h want 0/1/7/%h",
                 k, bus_if.data_req, regwr_en, regwr_sel, regwr_data, want[k]);
      end
      tick();
      n_cmp++;
      if ({regwr_en, pipe_in_rdy} !== 2'b01) begin
        n_fail++; $display("FAIL load_after got en=%b rdy=%b want 0/1", regwr_en, pipe_in_rdy);
      end
    end
  endtask

  task automatic test_store();
    pipeEXWB_t op;
    op = '0; op.st = 1'b1; op.funct3 = 3'b001; op.rd = 5'd3;
    op.result2 = 32'h2002; op.result1 = 32'h1234ABCD;
    send_op(op);
    n_cmp++;
    if ({bus_if.data_req, bus_if.data_wr_en, bus_if.data_mask, bus_if.data_wdata, bus_if.data_addr, regwr_en} !==
        {1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h2002, 1'b0}) begin
      n_fail++;
      $display("FAIL sh_issue got req=%b we=%b mask=%b wdata=%h addr=%h en=%b want 1/1/1100/abcdabcd/00002002/0",
               bus_if.data_req, bus_if.data_wr_en, bus_if.data_mask, bus_if.data_wdata, bus_if.data_addr, regwr_en);
    end
    bus_if.data_ack = 1'b1;
    tick();
    bus_if.data_ack = 1'b0;
    n_cmp++;
    if ({bus_if.data_req, regwr_en} !== 2'b00) begin
      n_fail++; $display("FAIL sh_done got req=%b en=%b want 0/0", bus_if.data_req, regwr_en);
    end
  endtask

  task automatic test_misaligned();
    pipeEXWB_t op;
    int        req_seen;
    op = '0; op.ld = 1'b1; op.funct3 = 3'b010; op.rd = 5'd4; op.rd_write = 1'b1; op.result2 = 32'h2001;
    send_op(op);
    req_seen = (bus_if.data_req === 1'b1) ? 1 : 0;
    n_cmp++;
    if ({trap, trap_cause, regwr_en} !== {1'b1, LD_MISALIGN, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_misalign got trap=%b cause=%0d en=%b want 1/%0d/0", trap, trap_cause, regwr_en, LD_MISALIGN);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus_if.data_req === 1'b1) req_seen++;
    end
    n_cmp++;
    if (req_seen !== 0) begin n_fail++; $display("FAIL lw_misalign_req got %0d req cycles want 0", req_seen); end
    n_cmp++;
    if (trap !== 1'b0) begin n_fail++; $display("FAIL trap_pulse trap=%b want 0", trap); end
  endtask

  task automatic test_trap_priority();
    pipeEXWB_t op;
    exp_t      e;
    for (int f = 1; f < 64; f++) begin
      op = '0; op.rd = 5'd9; op.rd_write = 1'b1; op.branch = 1'b1; op.result2 = 32'h40;
      {op.is_illegal, op.ecall, op.ebreak, op.csr, op.ret, op.wfi} = 6'(f);
      e = model(op, 32'd0);
      send_op(op);
      n_cmp++;
      if ({trap, trap_cause, regwr_en, branch, bus_if.data_req} !== {1'b1, e.cause, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL trap_prio flags=%b got trap=%b cause=%0d en=%b br=%b req=%b want 1/%0d/0/0/0",
                 6'(f), trap, trap_cause, regwr_en, branch, bus_if.data_req, e.cause);
      end
    end
  endtask

  task automatic test_stray_ack();
    int bad;
    bad = 0;
    bus_if.data_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus_if.data_rdata = $urandom;
      tick();
      if (regwr_en !== 1'b0 || bus_if.data_req !== 1'b0 || pipe_in_rdy !== 1'b1) bad++;
    end
    bus_if.data_ack = 1'b0;
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL stray_ack got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_wait();
    pipeEXWB_t op;
    op = '0; op.ld = 1'b1; op.funct3 = 3'b010; op.rd = 5'd6; op.rd_write = 1'b1; op.result2 = 32'h3000;
    send_op(op);
    tick();
    rstz = 1'b0;
    tick();
    n_cmp++;
    if ({bus_if.data_req, regwr_en, pipe_in_rdy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_wait got req=%b en=%b rdy=%b want 0/0/0", bus_if.data_req, regwr_en, pipe_in_rdy);
    end
    rstz = 1'b1;
    bus_if.data_ack = 1'b1; bus_if.data_rdata = 32'h12345678;
    tick();
    bus_if.data_ack = 1'b0;
    n_cmp++;
    if ({pipe_in_rdy, regwr_en, bus_if.data_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_wait_release got rdy=%b en=%b req=%b want 1/0/0", pipe_in_rdy, regwr_en, bus_if.data_req);
    end
  endtask

  task automatic test_random();
    pipeEXWB_t   op;
    exp_t        e;
    logic [31:0] rdata;
    logic [31:0] got_wd;
    int          delay;
    int          kind;
    for (int n = 0; n < 200; n++) begin
      op = '0;
      op.result1 = $urandom; op.result2 = $urandom;
      op.rd = 5'($urandom); op.rd_write = 1'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin op.branch = ($urandom_range(0, 3) == 0); op.branch_cond = 1'($urandom); end
        1: begin
          op.ld = 1'b1; op.rd_write = 1'b1;
          case ($urandom_range(0, 4))
            0: op.funct3 = 3'b000;
            1: op.funct3 = 3'b001;
            2: op.funct3 = 3'b010;
            3: op.funct3 = 3'b100;
            default: op.funct3 = 3'b101;
          endcase
        end
        2: begin op.st = 1'b1; op.funct3 = 3'($urandom_range(0, 2)); end
        default: {op.is_illegal, op.ecall, op.ebreak, op.csr, op.ret, op.wfi} = 6'($urandom_range(1, 63));
      endcase
      if ((kind == 1 || kind == 2) && $urandom_range(0, 1) == 1) op.result2[1:0] = 2'b00;
      rdata = $urandom;
      e = model(op, rdata);
      send_op(op);
      n_cmp++;
      if ({trap, regwr_en, branch, bus_if.data_req} !== {e.trap, e.wb_now, e.br, e.mem}) begin
        n_fail++;
        $display("FAIL rand_ctrl n=%0d got trap/en/br/req=%b want %b", n,
                 {trap, regwr_en, branch, bus_if.data_req}, {e.trap, e.wb_now, e.br, e.mem});
      end
      if (e.trap) begin
        n_cmp++;
        if (trap_cause !== e.cause) begin
          n_fail++; $display("FAIL rand_cause n=%0d got %0d want %0d", n, trap_cause, e.cause);
        end
      end
      if (e.wb_now) begin
        n_cmp++;
        if ({regwr_sel, regwr_data} !== {e.sel, e.wbdata}) begin
          n_fail++; $display("FAIL rand_alu_wb n=%0d got %0d/%h want %0d/%h", n, regwr_sel, regwr_data, e.sel, e.wbdata);
        end
      end
      if (e.br) begin
        n_cmp++;
        if (branch_target !== e.tgt) begin
          n_fail++; $display("FAIL rand_target n=%0d got %h want %h", n, branch_target, e.tgt);
        end
      end
      if (e.mem) begin
        got_wd = e.wr ? bus_if.data_wdata : 32'd0;
        n_cmp++;
        if ({bus_if.data_addr, bus_if.data_wr_en, bus_if.data_mask, got_wd} !== {e.addr, e.wr, e.mask, e.wdata}) begin
          n_fail++;
          $display("FAIL rand_bus n=%0d got addr=%h we=%b mask=%b wdata=%h want %h/%b/%b/%h", n,
                   bus_if.data_addr, bus_if.data_wr_en, bus_if.data_mask, got_wd, e.addr, e.wr, e.mask, e.wdata);
        end
        delay = $urandom_range(0, 3);
        for (int d = 0; d < delay; d++) begin
          tick();
          n_cmp++;
          if ({bus_if.data_req, bus_if.data_addr, regwr_en} !== {1'b1, e.addr, 1'b0}) begin
            n_fail++;
            $display("FAIL rand_hold n=%0d got req=%b addr=%h en=%b want 1/%h/0", n,
                     bus_if.data_req, bus_if.data_addr, regwr_en, e.addr);
          end
        end
        bus_if.data_rdata = rdata; bus_if.data_ack = 1'b1;
        tick();
        bus_if.data_ack = 1'b0; bus_if.data_rdata = $urandom;
        n_cmp++;
        if ({bus_if.data_req, regwr_en} !== {1'b0, e.wb_late}) begin
          n_fail++;
          $display("FAIL rand_done n=%0d got req=%b en=%b want 0/%b", n, bus_if.data_req, regwr_en, e.wb_late);
        end
        if (e.wb_late) begin
          n_cmp++;
          if ({regwr_sel, regwr_data} !== {e.sel, e.wbdata}) begin
            n_fail++;
            $display("FAIL rand_load_wb n=%0d f3=%b addr=%h rdata=%h got %0d/%h want %0d/%h", n, op.funct3,
                     op.result2, rdata, regwr_sel, regwr_data, e.sel, e.wbdata);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_trap_priority();
    test_stray_ack();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
